// File: rtl/nco_pkg.sv
// nco_pkg: shared types and helpers for the NCO clock generator.
//   ACC_W_DEFAULT : default accumulator / tuning-word width
//   ftw_t         : tuning word at the default width
//   lock_state_e  : lock FSM states
//   ftw_from_hz   : tuning word for a wanted output frequency, rounded to nearest
package nco_pkg;

  localparam int ACC_W_DEFAULT = 32;

  typedef logic [ACC_W_DEFAULT-1:0] ftw_t;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // f_out * 2^ACC_W / f_clk, rounded. Valid for f_out < 2^31 so the shift
  // stays inside 64 bits.
  function automatic ftw_t ftw_from_hz(input longint unsigned f_out,
                                       input longint unsigned f_clk);
    longint unsigned num;
    num = (f_out << ACC_W_DEFAULT) + (f_clk >> 1);
    return ftw_t'(num / f_clk);
  endfunction

endpackage

// File: rtl/nco_channel.sv
// nco_channel: one phase-accumulator NCO with a shadowed tuning word.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : run enable; accumulator held at 0 while low
//   wr_i          : accepted write strobe (only asserted when ready_o is high)
//   wr_data_i     : tuning word to park in the shadow register
//   phase_o       : registered accumulator value
//   clk_out_o     : accumulator MSB
//   carry_o       : carry-out of this cycle's add (combinational)
//   applied_o     : shadow is copied into the live tuning word this cycle
//   ready_o       : no update pending, a new write can be taken
module nco_channel
  import nco_pkg::*;
#(
  parameter int          ACC_W   = ACC_W_DEFAULT,
  parameter int unsigned FTW_RST = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wr_data_i,
  output logic [ACC_W-1:0] phase_o,
  output logic             clk_out_o,
  output logic             carry_o,
  output logic             applied_o,
  output logic             ready_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [ACC_W:0]   sum;
  logic             apply;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, ftw_q};
    // A running channel swaps tuning words only on the wrap add (which still
    // uses the old word), so the waveform never sees a shortened period.
    // A stopped channel has no waveform to protect and swaps at once.
    apply     = pending_q & (~en_i | sum[ACC_W]);
    acc_d     = en_i ? sum[ACC_W-1:0] : '0;
    ftw_d     = apply ? shadow_q : ftw_q;
    shadow_d  = wr_i ? wr_data_i : shadow_q;
    // wr_i and apply never coincide: writes are only taken while not pending.
    pending_d = wr_i | (pending_q & ~apply);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      ftw_q     <= ACC_W'(FTW_RST);
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ftw_q     <= ftw_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign phase_o   = acc_q;
  assign clk_out_o = acc_q[ACC_W-1];
  assign carry_o   = en_i & sum[ACC_W];
  assign applied_o = apply;
  assign ready_o   = ~pending_q;

endmodule

// File: rtl/nco_clkgen.sv
// nco_clkgen: multi-channel NCO clock synthesizer with glitch-free retuning
// and a settle/lock indicator.
//   clk, reset_n : system clock, asynchronous active-low reset
//   ftw_valid/ftw_ready/ftw_ch/ftw_data : tuning-word write handshake
//   en      : per-channel run enable
//   phase   : accumulators, channel i at [i*ACC_W +: ACC_W]
//   clk_out : accumulator MSB per channel
//   tick    : one-cycle pulse the cycle after a channel wraps
//   locked  : no retune or enable change for LOCK_CYCLES cycles
module nco_clkgen
  import nco_pkg::*;
#(
  parameter int          ACC_W       = ACC_W_DEFAULT,
  parameter int          CH          = 2,
  parameter int unsigned FTW_RST     = 0,
  parameter int          LOCK_CYCLES = 1024,
  localparam int         CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ftw_valid,
  output logic                  ftw_ready,
  input  logic [CH_W-1:0]       ftw_ch,
  input  logic [ACC_W-1:0]      ftw_data,
  input  logic [CH-1:0]         en,
  output logic [CH*ACC_W-1:0]   phase,
  output logic [CH-1:0]         clk_out,
  output logic [CH-1:0]         tick,
  output logic                  locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CH-1:0]    ch_ready;
  logic [CH-1:0]    ch_applied;
  logic [CH-1:0]    ch_carry;
  logic [CH-1:0]    wr;
  logic [CH-1:0]    tick_q;
  logic [CH-1:0]    en_q;
  logic             ready_mux;
  logic             lock_evt;
  lock_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             locked_q;

  // Out-of-range channel numbers match nothing and so read as ready; the
  // write is then accepted and simply dropped.
  always_comb begin
    ready_mux = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (ftw_ch == CH_W'(i)) ready_mux = ch_ready[i];
    end
  end
  assign ftw_ready = ready_mux;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign wr[gi] = ftw_valid & ch_ready[gi] & (ftw_ch == CH_W'(gi));

      nco_channel #(
        .ACC_W   (ACC_W),
        .FTW_RST (FTW_RST)
      ) u_ch (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (en[gi]),
        .wr_i      (wr[gi]),
        .wr_data_i (ftw_data),
        .phase_o   (phase[gi*ACC_W +: ACC_W]),
        .clk_out_o (clk_out[gi]),
        .carry_o   (ch_carry[gi]),
        .applied_o (ch_applied[gi]),
        .ready_o   (ch_ready[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_q <= '0;
    else          tick_q <= ch_carry;
  end
  assign tick = tick_q;

  // Deliberately not reset: it keeps following en while reset is held, so an
  // enable pattern that is steady across reset release is not seen as a toggle.
  always_ff @(posedge clk) begin
    en_q <= en;
  end

  assign lock_evt = (|ch_applied) | (en != en_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (lock_evt) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
            state_q  <= LOCKED;
            cnt_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (lock_evt) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end
        end
      endcase
    end
  end
  assign locked = locked_q;

endmodule

// File: tb/tb_nco_clkgen.sv
`timescale 1ns/1ps
module tb_nco_clkgen;

  localparam int ACC_W = 8;
  localparam int CH    = 3;
  localparam int LOCK  = 20;

  localparam int S_PHASE = 0;
  localparam int S_TICK  = 1;
  localparam int S_CLK   = 2;
  localparam int S_LOCK  = 3;
  localparam int S_READY = 4;

  logic                clk       = 1'b0;
  logic                reset_n   = 1'b0;
  logic                ftw_valid = 1'b0;
  logic                ftw_ready;
  logic [1:0]          ftw_ch    = 2'd0;
  logic [ACC_W-1:0]    ftw_data  = '0;
  logic [CH-1:0]       en        = 3'b001;
  logic [CH*ACC_W-1:0] phase;
  logic [CH-1:0]       clk_out;
  logic [CH-1:0]       tick;
  logic                locked;

  always #5 clk = ~clk;

  nco_clkgen #(
    .ACC_W       (ACC_W),
    .CH          (CH),
    .FTW_RST     (64),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .ftw_ch    (ftw_ch),
    .ftw_data  (ftw_data),
    .en        (en),
    .phase     (phase),
    .clk_out   (clk_out),
    .tick      (tick),
    .locked    (locked)
  );

  typedef struct {
    int cyc;
    int sig;
    int ch;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   rel     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  // ---------------- scoreboard monitor ----------------
  function automatic int actual(input int sig, input int ch);
    case (sig)
      S_PHASE: return int'(phase[ch*ACC_W +: ACC_W]);
      S_TICK:  return int'(tick[ch]);
      S_CLK:   return int'(clk_out[ch]);
      S_LOCK:  return int'(locked);
      default: return int'(ftw_ready);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_PHASE: return "phase";
      S_TICK:  return "tick";
      S_CLK:   return "clk_out";
      S_LOCK:  return "locked";
      default: return "ftw_ready";
    endcase
  endfunction

  always @(negedge clk) begin
    int   i;
    int   act;
    exp_t e;
    i = 0;
    while (i < exp_q.size()) begin
      e = exp_q[i];
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s ch%0d cyc %0d: never sampled, required %0d",
                 sig_name(e.sig), e.ch, e.cyc, e.val);
        exp_q.delete(i);
      end else if (e.cyc == cyc) begin
        n_tests++;
        act = actual(e.sig, e.ch);
        if (act != e.val) begin
          n_fail++;
          $display("FAIL %s ch%0d cyc %0d (k=%0d): got %0d, required %0d",
                   sig_name(e.sig), e.ch, e.cyc, e.cyc - rel, act, e.val);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int sig, input int ch, input int val);
    exp_t e;
    e.cyc = cyc;
    e.sig = sig;
    e.ch  = ch;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Reset-release behaviour: ch0 at FTW 64, others disabled.
  task automatic run_from_reset();
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) step();
      exp_push(S_PHASE, 0, (64 * k) % 256);
      exp_push(S_TICK,  0, (k > 0 && k % 4 == 0) ? 1 : 0);
      exp_push(S_CLK,   0, (k % 4 >= 2) ? 1 : 0);
      exp_push(S_LOCK,  0, (k >= LOCK) ? 1 : 0);
      exp_push(S_PHASE, 1, 0);
      exp_push(S_TICK,  1, 0);
      exp_push(S_CLK,   1, 0);
      exp_push(S_PHASE, 2, 0);
      if (k == 0) exp_push(S_READY, 0, 1);
    end
  endtask

  function automatic int ph0_128(input int k);  // ch0 at FTW 128 from k=52
    return ((k - 52) % 2 != 0) ? 128 : 0;
  endfunction

  function automatic int ph1_100(input int k);  // ch1 at FTW 100 from k=60
    return (100 * (k - 60)) % 256;
  endfunction

  initial begin
    int k;
    repeat (3) step();
    exp_push(S_PHASE, 0, 0);
    exp_push(S_TICK,  0, 0);
    exp_push(S_LOCK,  0, 0);
    exp_push(S_READY, 0, 1);
    reset_n = 1'b1;
    rel     = cyc;
    run_from_reset();

    // Glitch-free retune of ch0 from 64 to 32, written mid-period.
    step(); k = cyc - rel;                          // k = 25
    exp_push(S_PHASE, 0, 64);
    exp_push(S_READY, 0, 1);
    ftw_valid = 1'b1; ftw_ch = 2'd0; ftw_data = 8'd32;
    step();                                         // k = 26
    ftw_valid = 1'b0;
    exp_push(S_PHASE, 0, 128);
    exp_push(S_READY, 0, 0);
    step();                                         // k = 27
    exp_push(S_PHASE, 0, 192);
    exp_push(S_READY, 0, 0);
    exp_push(S_LOCK,  0, 1);
    for (int kk = 28; kk <= 50; kk++) begin
      step();
      exp_push(S_PHASE, 0, (32 * (kk - 28)) % 256);
      exp_push(S_TICK,  0, ((kk - 28) % 8 == 0) ? 1 : 0);
      exp_push(S_LOCK,  0, (kk >= 48) ? 1 : 0);
      exp_push(S_READY, 0, 1);
    end

    // Back-to-back writes: second ch0 write refused, ch1 write accepted.
    ftw_valid = 1'b1; ftw_ch = 2'd0; ftw_data = 8'd128;   // k = 50
    step();                                               // k = 51
    ftw_data = 8'd16;
    exp_push(S_READY, 0, 0);
    exp_push(S_PHASE, 0, 224);
    step();                                               // k = 52
    exp_push(S_PHASE, 0, 0);
    exp_push(S_TICK,  0, 1);
    exp_push(S_LOCK,  0, 0);
    ftw_ch = 2'd1; ftw_data = 8'd100;
    exp_push(S_READY, 1, 1);
    step();                                               // k = 53
    ftw_valid = 1'b0;
    exp_push(S_READY, 1, 0);
    exp_push(S_PHASE, 0, 128);
    exp_push(S_PHASE, 1, 0);
    step();                                               // k = 54
    exp_push(S_READY, 1, 1);
    exp_push(S_PHASE, 0, 0);
    exp_push(S_TICK,  0, 1);
    for (int kk = 55; kk <= 60; kk++) begin
      step();
      exp_push(S_PHASE, 0, ph0_128(kk));
      exp_push(S_CLK,   0, ph0_128(kk) >> 7);
      exp_push(S_TICK,  0, ((kk - 52) % 2 == 0) ? 1 : 0);
      exp_push(S_PHASE, 1, 0);
      exp_push(S_LOCK,  0, 0);
    end
    en = 3'b011;                                          // k = 60
    for (int kk = 61; kk <= 66; kk++) begin
      step();
      exp_push(S_PHASE, 1, ph1_100(kk));
      exp_push(S_TICK,  1, (kk == 63 || kk == 66) ? 1 : 0);
      exp_push(S_PHASE, 0, ph0_128(kk));
      exp_push(S_LOCK,  0, 0);
    end

    // FTW = 0 while enabled: frozen, no ticks.
    ftw_valid = 1'b1; ftw_ch = 2'd2; ftw_data = 8'd0;     // k = 66
    step();                                               // k = 67
    ftw_valid = 1'b0;
    step();                                               // k = 68
    en = 3'b111;
    for (int kk = 69; kk <= 72; kk++) begin
      step();
      exp_push(S_PHASE, 2, 0);
      exp_push(S_TICK,  2, 0);
      exp_push(S_PHASE, 1, ph1_100(kk));
    end

    // FTW = 255: tick on 255 of every 256 cycles.
    en = 3'b011; ftw_valid = 1'b1; ftw_ch = 2'd2; ftw_data = 8'd255;  // k = 72
    step();                                                           // k = 73
    ftw_valid = 1'b0;
    exp_push(S_PHASE, 2, 0);
    step();                                                           // k = 74
    exp_push(S_PHASE, 2, 0);
    en = 3'b111;
    for (int m = 1; m <= 257; m++) begin
      step();
      k = 74 + m;
      exp_push(S_PHASE, 2, (256 - (m % 256)) % 256);
      exp_push(S_TICK,  2, ((m - 1) % 256 != 0) ? 1 : 0);
      exp_push(S_LOCK,  0, (k >= 95) ? 1 : 0);
      exp_push(S_PHASE, 0, ph0_128(k));
      exp_push(S_PHASE, 1, ph1_100(k));
    end

    // Out-of-range channel: accepted, nothing changes, lock undisturbed.
    step();                                                           // k = 332
    ftw_valid = 1'b1; ftw_ch = 2'd3; ftw_data = 8'd7;
    exp_push(S_READY, 0, 1);
    exp_push(S_LOCK,  0, 1);
    for (int kk = 333; kk <= 340; kk++) begin
      step();
      ftw_valid = 1'b0; ftw_ch = 2'd0;
      exp_push(S_PHASE, 0, ph0_128(kk));
      exp_push(S_PHASE, 1, ph1_100(kk));
      exp_push(S_PHASE, 2, (256 - ((kk - 74) % 256)) % 256);
      exp_push(S_LOCK,  0, 1);
      exp_push(S_READY, 0, 1);
    end

    // Asynchronous reset while a ch0 write is pending.
    ftw_valid = 1'b1; ftw_ch = 2'd0; ftw_data = 8'd32;                // k = 340
    step();                                                           // k = 341
    ftw_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    en      = 3'b001;
    for (int c = 0; c < CH; c++) begin
      exp_push(S_PHASE, c, 0);
      exp_push(S_TICK,  c, 0);
      exp_push(S_CLK,   c, 0);
    end
    exp_push(S_LOCK,  0, 0);
    exp_push(S_READY, 0, 1);
    step();
    step();
    reset_n = 1'b1;
    rel     = cyc;
    run_from_reset();

    step();
    step();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
